// File: rtl/prbs_checker.sv
// PRBS-16 serial checker (x^16+x^14+x^13+x^11+1).
// Acquires lock by filling a 16-bit predictor from the incoming stream and
// verifying a run of correct predictions. Once locked it free-runs its own
// predictor and counts every corrupted bit. Lock is dropped when too many
// mismatches fall within one window of valid bits.
module prbs_checker #(
  parameter int LOCK_COUNT = 16,
  parameter int LOSS_ERR   = 4,
  parameter int WINDOW     = 64
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int XW = $clog2(LOSS_ERR + 1);
  localparam int WW = $clog2(WINDOW + 1);

  // Counters are compared against "last value before the event" so that the
  // event fires on the bit that would bring the count to its limit.
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [XW-1:0] MISS_LAST  = XW'(LOSS_ERR - 1);
  localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'b00,
    ST_VERIFY = 2'b01,
    ST_LOCKED = 2'b10
  } state_t;

  // Pin unpacking
  logic clk;
  logic rst;
  logic din;
  logic din_valid;
  logic clr_cnt;
  logic invert;
  logic unused_io;

  assign clk       = io_in[0];
  assign rst       = io_in[1];
  assign din       = io_in[2];
  assign din_valid = io_in[3];
  assign clr_cnt   = io_in[4];
  assign invert    = io_in[5];
  assign unused_io = ^io_in[7:6];

  // State
  state_t        state_q,   state_d;
  logic [15:0]   sr_q,      sr_d;
  logic [4:0]    fill_q,    fill_d;
  logic [MW-1:0] match_q,   match_d;
  logic [XW-1:0] miss_q,    miss_d;
  logic [WW-1:0] win_q,     win_d;
  logic [3:0]    err_cnt_q, err_cnt_d;
  logic          err_q,     err_d;
  logic          locked_q,  locked_d;

  // Datapath helpers
  logic        d_bit;
  logic        p_bit;
  logic [15:0] sr_shift_d;
  logic        count_err;

  assign d_bit      = din ^ invert;
  assign p_bit      = sr_q[15] ^ sr_q[13] ^ sr_q[12] ^ sr_q[10];
  assign sr_shift_d = {sr_q[14:0], d_bit};

  // Next-state logic: acquisition FSM, window bookkeeping and error counter
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    fill_d    = fill_q;
    match_d   = match_q;
    miss_d    = miss_q;
    win_d     = win_q;
    err_cnt_d = err_cnt_q;
    count_err = 1'b0;

    if (din_valid) begin
      case (state_q)
        ST_SEARCH: begin
          sr_d = sr_shift_d;
          if (fill_q == 5'd15) begin
            fill_d = 5'd0;
            // An all-zero predictor would lock onto the LFSR lockup state,
            // so a zero fill simply starts another fill.
            if (sr_shift_d != 16'd0) begin
              state_d = ST_VERIFY;
              match_d = '0;
            end
          end else begin
            fill_d = fill_q + 5'd1;
          end
        end

        ST_VERIFY: begin
          sr_d = sr_shift_d;
          if (d_bit == p_bit) begin
            if (match_q == MATCH_LAST) begin
              state_d = ST_LOCKED;
              match_d = '0;
              miss_d  = '0;
              win_d   = '0;
            end else begin
              match_d = match_q + MW'(1);
            end
          end else begin
            state_d = ST_SEARCH;
            fill_d  = 5'd0;
          end
        end

        ST_LOCKED: begin
          // Free-run on the prediction so a corrupted bit never pollutes
          // the predictor and is counted exactly once.
          sr_d      = {sr_q[14:0], p_bit};
          count_err = (d_bit != p_bit);
          if (count_err && (miss_q == MISS_LAST)) begin
            // Loss of lock takes priority over the window-end clear.
            state_d = ST_SEARCH;
            fill_d  = 5'd0;
            miss_d  = '0;
            win_d   = '0;
          end else if (win_q == WIN_LAST) begin
            win_d  = '0;
            miss_d = '0;
          end else begin
            win_d = win_q + WW'(1);
            if (count_err) begin
              miss_d = miss_q + XW'(1);
            end
          end
        end

        default: begin
          state_d = ST_SEARCH;
          fill_d  = 5'd0;
        end
      endcase
    end

    // Clear wins over a simultaneous mismatch
    if (clr_cnt) begin
      err_cnt_d = 4'd0;
    end else if (count_err && (err_cnt_q != 4'hF)) begin
      err_cnt_d = err_cnt_q + 4'd1;
    end

    err_d    = count_err;
    locked_d = (state_d == ST_LOCKED);
  end

  // State and registered outputs, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_SEARCH;
      sr_q      <= 16'd0;
      fill_q    <= 5'd0;
      match_q   <= '0;
      miss_q    <= '0;
      win_q     <= '0;
      err_cnt_q <= 4'd0;
      err_q     <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      win_q     <= win_d;
      err_cnt_q <= err_cnt_d;
      err_q     <= err_d;
      locked_q  <= locked_d;
    end
  end

  assign io_out = {state_q, err_cnt_q, err_q, locked_q};

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: directed PRBS streams with hand-computed
// checkpoints, plus a queue-based reference model compared every cycle.
module tb_prbs_checker;

  localparam int LOCK_COUNT = 16;
  localparam int LOSS_ERR   = 4;
  localparam int WINDOW     = 64;

  logic       clk       = 1'b0;
  logic       rst       = 1'b0;
  logic       din       = 1'b0;
  logic       din_valid = 1'b0;
  logic       clr       = 1'b0;
  logic       invert    = 1'b0;
  logic [1:0] spare     = 2'b00;
  logic [7:0] io_in;
  logic [7:0] io_out;

  assign io_in = {spare, invert, clr, din_valid, din, rst, clk};

  prbs_checker #(
    .LOCK_COUNT(LOCK_COUNT),
    .LOSS_ERR  (LOSS_ERR),
    .WINDOW    (WINDOW)
  ) dut (
    .io_in (io_in),
    .io_out(io_out)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int bad    = 0;
  int pulses = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp, input bit quiet);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end else if (!quiet) begin
      $display("check %s: got %0d want %0d ok", name, act, exp);
    end
  endtask

  // Reference model: predictor kept as a queue of the last 16 bits, oldest
  // first, so sr[15] is mh[0] and sr[k] is mh[15-k].
  int m_state, m_fill, m_match, m_miss, m_win, m_cnt, mz;
  bit m_err, md, mp, mcounted;
  bit mh[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0; m_fill = 0; m_match = 0; m_miss = 0; m_win = 0;
      m_cnt = 0; m_err = 1'b0;
      mh.delete();
      for (int i = 0; i < 16; i++) mh.push_back(1'b0);
    end else begin
      mcounted = 1'b0;
      if (din_valid) begin
        md = din ^ invert;
        mp = mh[0] ^ mh[2] ^ mh[3] ^ mh[5];
        if (m_state == 0) begin
          void'(mh.pop_front()); mh.push_back(md);
          m_fill++;
          if (m_fill == 16) begin
            m_fill = 0;
            mz = 0;
            foreach (mh[i]) mz += int'(mh[i]);
            if (mz != 0) begin m_state = 1; m_match = 0; end
          end
        end else if (m_state == 1) begin
          void'(mh.pop_front()); mh.push_back(md);
          if (md == mp) begin
            m_match++;
            if (m_match == LOCK_COUNT) begin
              m_state = 2; m_miss = 0; m_win = 0;
            end
          end else begin
            m_state = 0; m_fill = 0;
          end
        end else begin
          void'(mh.pop_front()); mh.push_back(mp);
          m_win++;
          if (md != mp) begin mcounted = 1'b1; m_miss++; end
          if (m_miss == LOSS_ERR) begin
            m_state = 0; m_fill = 0;
          end else if (m_win == WINDOW) begin
            m_win = 0; m_miss = 0;
          end
        end
      end
      if (clr) m_cnt = 0;
      else if (mcounted && m_cnt < 15) m_cnt++;
      m_err = mcounted;
    end
  end

  // Compare process: every falling edge, the whole output byte
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cycle_out", int'(io_out),
          int'({m_state[1:0], m_cnt[3:0], m_err, (m_state == 2)}), 1'b1);
      if (io_out[1]) pulses++;
    end
  end

  // Stimulus helpers (called on a falling edge, return on the next one)
  logic [15:0] g = 16'hACE1;
  bit gb;
  int zero_viol;

  task automatic next_bit(output bit b);
    b = g[15] ^ g[13] ^ g[12] ^ g[10];
    g = {g[14:0], b};
  endtask

  task automatic send(input bit b, input bit v, input bit c, input bit inv);
    din = b; din_valid = v; clr = c; invert = inv;
    spare = 2'($urandom_range(0, 3));
    @(negedge clk);
  endtask

  task automatic prbs(input int n);
    bit b;
    for (int i = 0; i < n; i++) begin
      next_bit(b);
      send(b, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic flip(input int n);
    bit b;
    for (int i = 0; i < n; i++) begin
      next_bit(b);
      send(~b, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1 chk("reset_async_out", int'(io_out), 0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    chk_en = 1'b1;
    pulse_reset();

    // Acquisition from a clean stream seeded with 0xACE1
    prbs(16);
    chk("verify_after_16", int'(io_out[7:6]), 1, 1'b0);
    prbs(16);
    chk("locked_after_32", int'(io_out[0]), 1, 1'b0);
    chk("state_locked", int'(io_out[7:6]), 2, 1'b0);
    prbs(968);
    chk("err_cnt_1000_clean", int'(io_out[5:2]), 0, 1'b0);

    // Two isolated bit errors 200 bits apart
    pulses = 0;
    prbs(99); flip(1); prbs(199); flip(1); prbs(200);
    chk("two_err_pulses", pulses, 2, 1'b0);
    chk("err_cnt_two", int'(io_out[5:2]), 2, 1'b0);
    chk("still_locked", int'(io_out[0]), 1, 1'b0);

    // Counter clear with a clean bit
    next_bit(gb);
    send(gb, 1'b1, 1'b1, 1'b0);
    chk("clr_cnt", int'(io_out[5:2]), 0, 1'b0);

    // Four errors inside one window drop lock, then relock
    prbs(10);
    flip(1); prbs(1); flip(1); prbs(1); flip(1); prbs(1); flip(1);
    chk("loss_on_4th", int'(io_out[7:6]), 0, 1'b0);
    chk("err_cnt_four", int'(io_out[5:2]), 4, 1'b0);
    prbs(16);
    chk("reverify_16", int'(io_out[7:6]), 1, 1'b0);
    prbs(16);
    chk("relock_32", int'(io_out[0]), 1, 1'b0);
    chk("err_cnt_kept", int'(io_out[5:2]), 4, 1'b0);

    // Asynchronous reset while locked, then reacquire
    pulse_reset();
    prbs(32);
    chk("relock_after_rst", int'(io_out[0]), 1, 1'b0);
    chk("err_cnt_after_rst", int'(io_out[5:2]), 0, 1'b0);

    // Three errors at the end of a window plus three at the start of the
    // next must not drop lock; a fourth does.
    prbs(61); flip(3); flip(3);
    chk("window_split_locked", int'(io_out[0]), 1, 1'b0);
    flip(1);
    chk("window_split_loss", int'(io_out[7:6]), 0, 1'b0);
    prbs(32);
    chk("relock_again", int'(io_out[0]), 1, 1'b0);
    // Fourth error on the last bit of a window still drops lock
    prbs(60); flip(4);
    chk("loss_at_window_end", int'(io_out[7:6]), 0, 1'b0);
    chk("err_cnt_eleven", int'(io_out[5:2]), 11, 1'b0);

    // All-zero input never leaves SEARCH
    pulse_reset();
    zero_viol = 0;
    for (int i = 0; i < 48; i++) begin
      send(1'b0, 1'b1, 1'b0, 1'b0);
      if (io_out[7:6] != 2'b00 || io_out[0]) zero_viol++;
    end
    chk("zeros_stay_search", zero_viol, 0, 1'b0);
    chk("zeros_out", int'(io_out), 0, 1'b0);

    // Inverted data with din_valid toggling: saturate the error counter
    prbs(32);
    chk("lock_before_invert", int'(io_out[0]), 1, 1'b0);
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 4; k++) begin
        next_bit(gb);
        send(gb, 1'b1, 1'b0, 1'b1);
        send(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
      end
      if (r == 0) chk("invert_loss", int'(io_out[7:6]), 0, 1'b0);
      prbs(32);
      chk("invert_relock", int'(io_out[0]), 1, 1'b0);
      if (r == 2) chk("err_cnt_twelve", int'(io_out[5:2]), 12, 1'b0);
      if (r >= 3) chk("err_cnt_saturated", int'(io_out[5:2]), 15, 1'b0);
    end

    // Clear together with a mismatch: clear wins, err still pulses
    next_bit(gb);
    send(~gb, 1'b1, 1'b1, 1'b0);
    chk("clr_beats_err", int'(io_out[5:2]), 0, 1'b0);
    chk("err_pulse_with_clr", int'(io_out[1]), 1, 1'b0);
    prbs(1);
    chk("err_pulse_one_cycle", int'(io_out[1]), 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
